// File: rtl/expand_arbiter.sv
// Round-robin arbiter feeding one narrow-to-wide expander. A grant is locked
// for BURST accepted beats so each wide word carries data from one producer.
module expand_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 64,
  parameter int ID_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN*IN_WIDTH-1:0] din,
  input  logic [NUM_IN-1:0]          vld_in,
  output logic [NUM_IN-1:0]          rdy_upward,
  output logic [IN_WIDTH-1:0]        dout,
  output logic                       vld_out,
  input  logic                       rdy_downward,
  output logic [ID_WIDTH-1:0]        grant_id,
  output logic                       grant_vld,
  output logic                       burst_done
);

  localparam int BURST = OUT_WIDTH / IN_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_reg;
  logic [ID_WIDTH-1:0] ptr_reg;
  logic [31:0]         cnt_reg;

  logic [IN_WIDTH-1:0] din_arr [NUM_IN];
  logic [ID_WIDTH-1:0] cand_id [NUM_IN];
  logic [NUM_IN-1:0]   req_rot;
  logic [ID_WIDTH-1:0] sel_id;
  logic                any_req;
  logic                active;
  logic                xfer;
  logic                last_beat;

  // Outputs are forced quiet while reset is asserted, even mid-burst.
  assign active = (state_reg == GRANT) && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_port
      logic [ID_WIDTH:0] cand_sum;
      assign din_arr[gi]    = din[gi*IN_WIDTH +: IN_WIDTH];
      assign rdy_upward[gi] = active && (grant_id == ID_WIDTH'(gi)) && rdy_downward;
      // cand_id[gi] is the requester visited gi steps after ptr, modulo NUM_IN.
      assign cand_sum    = {1'b0, ptr_reg} + (ID_WIDTH+1)'(gi);
      assign cand_id[gi] = (cand_sum >= (ID_WIDTH+1)'(NUM_IN))
                         ? ID_WIDTH'(cand_sum - (ID_WIDTH+1)'(NUM_IN))
                         : ID_WIDTH'(cand_sum);
      assign req_rot[gi] = vld_in[cand_id[gi]];
    end
  endgenerate

  // Walk from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    sel_id  = '0;
    any_req = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_id  = cand_id[k];
        any_req = 1'b1;
      end
    end
  end

  assign dout       = active ? din_arr[grant_id] : '0;
  assign vld_out    = active && vld_in[grant_id];
  assign grant_vld  = active;
  assign xfer       = vld_out && rdy_downward;
  assign last_beat  = xfer && (cnt_reg == 32'(BURST - 1));
  assign burst_done = last_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_id  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_id  <= sel_id;
            cnt_reg   <= '0;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          if (last_beat) begin
            ptr_reg   <= (grant_id == ID_WIDTH'(NUM_IN - 1)) ? '0 : grant_id + 1'b1;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (xfer) begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expand_arbiter.sv
// Scoreboard bench for expand_arbiter: stimulus queues expected beats, a
// negedge monitor pops and compares each accepted beat.
module tb_expand_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din;
  logic [3:0]   vld_in;
  logic [3:0]   rdy_upward;
  logic [31:0]  dout;
  logic         vld_out;
  logic         rdy_downward;
  logic [1:0]   grant_id;
  logic         grant_vld;
  logic         burst_done;

  expand_arbiter #(
    .NUM_IN(4), .IN_WIDTH(32), .OUT_WIDTH(64), .ID_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .vld_in(vld_in),
    .rdy_upward(rdy_upward), .dout(dout), .vld_out(vld_out),
    .rdy_downward(rdy_downward), .grant_id(grant_id),
    .grant_vld(grant_vld), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] P0 = 32'hAAAA_0000;
  localparam logic [31:0] P1 = 32'hBBBB_0001;
  localparam logic [31:0] P2 = 32'hCCCC_0002;
  localparam logic [31:0] P3 = 32'hDDDD_0003;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && vld_out && rdy_downward) begin
      $display("[TB] beat id=%0d data=%08h done=%0b", grant_id, dout, burst_done);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got id %0d data %08h, required no transfer", grant_id, dout);
      end else begin
        mon_e = sb.pop_front();
        check("beat_id",   64'(grant_id),   64'(mon_e.id));
        check("beat_data", 64'(dout),       64'(mon_e.data));
        check("beat_done", 64'(burst_done), 64'(mon_e.done));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] d, input logic done);
    exp_t e;
    e.id = id; e.data = d; e.done = done;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      step();
      n++;
    end
    check(name, 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    vld_in       = 4'b1111;
    rdy_downward = 1'b1;
    din          = {P3, P2, P1, P0};

    // Reset held 3 cycles with all requesters valid
    repeat (3) begin
      step();
      check("rst_rdy_upward", 64'(rdy_upward), 64'(0));
      check("rst_vld_out",    64'(vld_out),    64'(0));
      check("rst_dout",       64'(dout),       64'(0));
      check("rst_grant_id",   64'(grant_id),   64'(0));
      check("rst_grant_vld",  64'(grant_vld),  64'(0));
      check("rst_burst_done", 64'(burst_done), 64'(0));
    end

    // Fairness: 5 bursts of 2 beats, each followed by one idle cycle
    reset = 1'b0;
    push(0, P0, 0); push(0, P0, 1);
    push(1, P1, 0); push(1, P1, 1);
    push(2, P2, 0); push(2, P2, 1);
    push(3, P3, 0); push(3, P3, 1);
    push(0, P0, 0); push(0, P0, 1);
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      step();
      n++;
    end
    check("fair_cycles", 64'(n), 64'(15));
    sb.delete();
    vld_in = 4'b0000;

    // Single requester 2, beats 0xA then 0xB (ptr is now 1)
    din[2*32 +: 32] = 32'h0000_000A;
    vld_in = 4'b0100;
    push(2, 32'h0000_000A, 0); push(2, 32'h0000_000B, 1);
    step();
    check("single_grant_id",  64'(grant_id),  64'(2));
    check("single_grant_vld", 64'(grant_vld), 64'(1));
    check("single_dout_a",    64'(dout),      64'(32'hA));
    step();
    din[2*32 +: 32] = 32'h0000_000B;
    step();
    vld_in = 4'b0000;
    check("single_idle", 64'(grant_vld), 64'(0));
    check("single_drained", 64'(sb.size()), 64'(0));
    sb.delete();

    // Backpressure on producer 3 with producer 1 also requesting (ptr is 3)
    din[3*32 +: 32] = 32'hDDDD_1111;
    vld_in = 4'b1010;
    push(3, 32'hDDDD_1111, 0); push(3, 32'hDDDD_2222, 1);
    step();
    check("bp_grant_id", 64'(grant_id), 64'(3));
    step();
    rdy_downward = 1'b0;
    repeat (3) begin
      #1;
      check("bp_rdy_upward", 64'(rdy_upward), 64'(0));
      check("bp_burst_done", 64'(burst_done), 64'(0));
      check("bp_vld_out",    64'(vld_out),    64'(1));
      check("bp_grant_id",   64'(grant_id),   64'(3));
      step();
    end
    rdy_downward = 1'b1;
    din[3*32 +: 32] = 32'hDDDD_2222;
    #1;
    check("bp_rdy_resume", 64'(rdy_upward), 64'(4'b1000));
    check("bp_done",       64'(burst_done), 64'(1));
    step();
    vld_in = 4'b0000;
    check("bp_idle", 64'(grant_vld), 64'(0));
    check("bp_drained", 64'(sb.size()), 64'(0));
    sb.delete();

    // Lock: producer 1 drops valid mid-burst while producer 3 waits (ptr is 0)
    din[1*32 +: 32] = 32'hBBBB_1111;
    vld_in = 4'b0010;
    push(1, 32'hBBBB_1111, 0); push(1, 32'hBBBB_2222, 1);
    push(3, 32'hDDDD_2222, 0); push(3, 32'hDDDD_2222, 1);
    step();
    step();
    vld_in = 4'b1000;
    repeat (5) begin
      #1;
      check("lock_grant_id",  64'(grant_id),   64'(1));
      check("lock_rdy",       64'(rdy_upward), 64'(4'b0010));
      check("lock_vld_out",   64'(vld_out),    64'(0));
      check("lock_grant_vld", 64'(grant_vld),  64'(1));
      step();
    end
    vld_in = 4'b1010;
    din[1*32 +: 32] = 32'hBBBB_2222;
    drain("lock_drained");
    vld_in = 4'b0000;

    // Reset mid-burst: complete burst on 1 (ptr -> 2), partial on 2, then reset
    din[1*32 +: 32] = P1;
    din[2*32 +: 32] = P2;
    vld_in = 4'b0010;
    push(1, P1, 0); push(1, P1, 1);
    drain("pre_reset_drained");
    vld_in = 4'b0100;
    push(2, P2, 0);
    step();
    check("mid_grant_id", 64'(grant_id), 64'(2));
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_vld_out", 64'(vld_out),    64'(0));
    check("mid_rst_rdy",     64'(rdy_upward), 64'(0));
    step();
    reset  = 1'b0;
    vld_in = 4'b1111;
    check("mid_rst_idle",     64'(grant_vld), 64'(0));
    check("mid_rst_grant_id", 64'(grant_id),  64'(0));
    check("mid_rst_partial",  64'(sb.size()), 64'(0));
    sb.delete();
    push(0, P0, 0); push(0, P0, 1);
    drain("post_reset_drained");
    vld_in = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
